// File: rtl/serial_shifter.sv
// serial_shifter: multi-cycle variable shifter (SLL/SRL/SRA), one bit per clock.
// Ports:
//   clk_i    - clock, rising edge
//   rst_i    - asynchronous active-low reset
//   start_i  - request, accepted in IDLE or DONE
//   op_i     - 00 SLL, 01 SRL, 10 SRA, 11 reserved (pass-through)
//   data_i   - operand, captured on the accepting edge
//   shamt_i  - unsigned shift amount, captured on the accepting edge
//   busy_o   - high while shifting
//   done_o   - one-cycle completion pulse
//   data_o   - result register, updated only on completion
module serial_shifter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [1:0]         op_i,
    input  logic [WIDTH-1:0]   data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [WIDTH-1:0]   data_o
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    state_e             state_q,  state_d;
    logic [WIDTH-1:0]   work_q,   work_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [SHAMT_W-1:0] count_q,  count_d;
    logic [1:0]         op_q,     op_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            result_q <= '0;
            count_q  <= '0;
            op_q     <= OP_SLL;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            result_q <= result_d;
            count_q  <= count_d;
            op_q     <= op_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state, shift datapath and registered-output decode
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        result_d = result_q;
        count_d  = count_q;
        op_d     = op_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    work_d  = data_i;
                    op_d    = op_i;
                    // Reserved op passes the operand through untouched
                    count_d = (op_i == OP_RSV) ? '0 : shamt_i;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (count_q != '0) begin
                    case (op_q)
                        OP_SLL:  work_d = {work_q[WIDTH-2:0], 1'b0};
                        OP_SRL:  work_d = {1'b0, work_q[WIDTH-1:1]};
                        OP_SRA:  work_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
                        default: work_d = work_q;
                    endcase
                    count_d = count_q - SHAMT_W'(1);
                end else begin
                    result_d = work_q;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decodes of the next state so they line up with state_q
        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign data_o = result_q;

endmodule
